// File: rtl/pipe_run_ctrl.sv
// Run/halt/single-step sequencer and load-use hazard controller for the 5-stage pipeline.
// Also selects EX-stage operand forwarding and keeps debug cycle/stall counters.
module pipe_run_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic                  clr_cnt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wreg,
    input  logic                  ex_m2reg,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_wreg,
    input  logic                  mem_m2reg,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  running,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_ex_load_dst;
    logic                  w_load_use;
    logic                  w_active;
    logic                  w_issue;
    logic [CNT_W-1:0]      r_cycle_cnt;
    logic [CNT_W-1:0]      r_stall_cnt;

    // EX wins over MEM; register 0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] e_rd,
        input logic                  e_wreg,
        input logic                  e_m2reg,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_wreg,
        input logic                  m_m2reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (e_wreg && (e_rd != '0) && (e_rd == src) && !e_m2reg) begin
            sel = 2'b01;
        end else if (m_wreg && (m_rd != '0) && (m_rd == src)) begin
            sel = m_m2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    assign w_ex_load_dst = ex_wreg & ex_m2reg & (ex_rd != '0);
    assign w_load_use    = w_ex_load_dst &
                           ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    assign fwd_a = fwd_sel(id_rs, ex_rd, ex_wreg, ex_m2reg, mem_rd, mem_wreg, mem_m2reg);
    assign fwd_b = id_uses_rt ?
                   fwd_sel(id_rt, ex_rd, ex_wreg, ex_m2reg, mem_rd, mem_wreg, mem_m2reg) :
                   2'b00;

    assign w_active    = (r_state != ST_HALT);
    assign w_issue     = w_active & ~w_load_use;
    assign running     = w_active;
    assign pc_en       = w_issue;
    assign ifid_en     = w_issue;
    assign idex_bubble = ~w_issue;
    assign cycle_cnt   = r_cycle_cnt;
    assign stall_cnt   = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A step only completes on a cycle that actually issues; stall cycles keep STEP.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_HALT: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (step_req) begin
                    w_state_nxt = ST_STEP;
                end else if (run_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_STEP: begin
                if (halt_req || !w_load_use) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (w_active) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (w_load_use) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

endmodule
